gray_sweep_ctrl: RTL and testbench
==================================

Name: gray_sweep_ctrl

Overview:
- Sequencer for the two-digit (8-bit) gray counter.
- Drives the counter's en/dir so it seeks to a programmed lower limit, then sweeps between lower and upper limits, once or ping-pong for N round trips, at a programmable step rate.
- Keeps a binary shadow of the counter position and checks the counter's gray output against it after every step.
- Sits between the configuration/command source and the counter instance.

Parameters:
- DIV_W, 8, width of the step-rate divider (cfg_div).
- LOOP_W, 4, width of the round-trip count (cfg_loops).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  synchronous, active-high reset (name kept per codebase port naming; asserted = 1).
- start_valid  in  1  start request.
- start_ready  out  1  high only in IDLE with stop low; start accepted when valid&&ready.
- stop  in  1  abort; priority over everything except reset.
- cfg_lo  in  8  lower limit, binary position, sampled at accept.
- cfg_hi  in  8  upper limit, binary, sampled at accept.
- cfg_mode  in  1  0 = single up-sweep, 1 = ping-pong; sampled at accept.
- cfg_loops  in  LOOP_W  ping-pong round trips; 0 = unlimited; sampled at accept.
- cfg_div  in  DIV_W  step every cfg_div+1 cycles; sampled at accept.
- cnt_gray  in  8  counter output, {g(pos[7:4]), g(pos[3:0])} with g(b) = b^(b>>1).
- cnt_en  out  1  one-cycle step pulse to the counter.
- cnt_dir  out  1  1 = up, 0 = down; valid whenever cnt_en = 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- cfg_err  out  1  set on lo > hi at accept; cleared at next accept.
- trk_err  out  1  sticky gray mismatch; cleared at accept.
- pos  out  8  binary shadow position.

Behaviour:
- Reset: state IDLE, pos = 0, prescaler = 0; cnt_en, cnt_dir, busy, done, cfg_err, trk_err all 0. pos = 0 matches the counter's reset value.
- States: IDLE, SEEK, UP, DOWN, DONE.
- Accept at cycle T:
  - Latch config; clear prescaler, cfg_err and trk_err.
  - If lo > hi: set cfg_err and go to DONE.
  - Otherwise go to SEEK. Loop counter = cfg_loops.
- Tick: prescaler counts 0..cfg_div and wraps; the tick is high in the cycle prescaler == cfg_div. With div = 0 there is a tick every cycle.
- Per tick, target = lo in SEEK and DOWN, hi in UP:
  - pos != target: cnt_en = 1 for that cycle only, cnt_dir = (target > pos). pos increments or decrements on the same edge as the counter.
  - pos == target: no pulse; take the state transition.
- Transitions, on a tick with pos == target:
  - SEEK goes to UP.
  - UP goes to DONE when mode = 0. When mode = 1 it goes to DOWN.
  - DOWN: if loops == 1, go to DONE. Otherwise decrement loops (no decrement when loops = 0, i.e. unlimited) and go to UP.
- lo == hi: each phase completes with zero pulses.
- DONE lasts one cycle with done = 1, busy = 1; then IDLE.
- No wrap-around: pos always stays within [min(pos_start, lo), max(pos_start, hi)].
- Tracking check: in the cycle after every cnt_en pulse, cnt_gray must equal g-map(pos), else trk_err sets. trk_err stays 1 until the next accept and does not stop sequencing.
- stop in any non-IDLE state:
  - Next state IDLE; cnt_en forced 0 in the stop cycle itself.
  - done not pulsed; pos retained.
- stop and start_valid together in IDLE: start is not accepted.
- Reset mid-operation: all outputs to reset values on the next edge. The counter is reset by the same rst domain, so pos = 0 stays consistent.
- Width rules:
  - pos arithmetic is 8-bit, never wraps.
  - Prescaler and loop counter are unsigned at DIV_W and LOOP_W.

Decomposition:
- Shared package:
  - state enum (IDLE, SEEK, UP, DOWN, DONE);
  - bin-to-gray function for the 8-bit two-digit map;
  - DIR_UP = 1, DIR_DOWN = 0 constants.
- One sub-module: gray_sweep_tick (prescaler with clear and div input, tick output). The FSM and shadow tracking stay in the top module.

Test Plan:
1. From reset, lo=3, hi=5, mode=0, div=0, accept at T:
   - cnt_en=1, dir=1 at T+1, T+2, T+3, T+5, T+6 (no pulse at T+4); pos=5 at T+7.
   - done=1 at T+8; busy=0 and start_ready=1 at T+9; cnt_gray=8'h07.
2. Same config with div=2: pulses exactly 3 cycles apart; first pulse at T+3; 5 pulses total.
3. pos=5, lo=2, hi=4, mode=1, loops=2:
   - seek 3 pulses dir=0 (pos 5 to 2), then up 2, down 2, up 2, down 2;
   - done after the second DOWN; final pos=2, cnt_gray=8'h03.
4. lo=9, hi=4: cfg_err=1 and done=1 at T+1; zero cnt_en pulses; next accept with a valid config clears cfg_err.
5. Stop and mismatch:
   - stop asserted mid-UP: no cnt_en from that cycle, IDLE next cycle, no done, pos held.
   - Separately, force cnt_gray wrong for the cycle after one pulse: trk_err=1 and stays set while the sweep still completes.
6. Reset and priority:
   - rst_n=1 mid-SEEK: next cycle all outputs 0, pos=0, state IDLE.
   - start_valid together with stop in IDLE: not accepted.

Source files
------------

// File: rtl/gray_sweep_ctrl_pkg.sv
// Shared types and helpers for the gray counter sweep sequencer.
package gray_sweep_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, SEEK, UP, DOWN, DONE} state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       mode;
  } sweep_cfg_t;

  // Two independent 4-bit gray digits, matching the counter's output encoding.
  function automatic logic [7:0] bin2gray(input logic [7:0] b);
    return {b[7:4] ^ {1'b0, b[7:5]}, b[3:0] ^ {1'b0, b[3:1]}};
  endfunction

endpackage

// File: rtl/gray_sweep_tick.sv
// Step-rate prescaler: tick is high once every div+1 cycles; clr restarts the phase.
module gray_sweep_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst_n)           cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (cnt == div) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == div);

endmodule

// File: rtl/gray_sweep_ctrl.sv
// Seeks the gray counter to lo, then sweeps lo..hi once or ping-pong, tracking a binary shadow.
module gray_sweep_ctrl
  import gray_sweep_ctrl_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int LOOP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              stop,
  input  logic [7:0]        cfg_lo,
  input  logic [7:0]        cfg_hi,
  input  logic              cfg_mode,
  input  logic [LOOP_W-1:0] cfg_loops,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [7:0]        cnt_gray,
  output logic              cnt_en,
  output logic              cnt_dir,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              trk_err,
  output logic [7:0]        pos
);

  state_t            state;
  sweep_cfg_t        cfg_q;
  logic [LOOP_W-1:0] loops_q;
  logic [DIV_W-1:0]  div_q;
  logic              chk_pend;
  logic              tick;
  logic              accept;
  logic              active;
  logic [7:0]        target;
  logic              at_tgt;
  logic              dir_up;
  logic              step;
  logic              advance;

  gray_sweep_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .div   (div_q),
    .tick  (tick)
  );

  assign start_ready = (state == IDLE) && !stop;
  assign accept      = start_valid && start_ready;
  assign active      = (state == SEEK) || (state == UP) || (state == DOWN);
  assign target      = (state == UP) ? cfg_q.hi : cfg_q.lo;
  assign at_tgt      = (pos == target);
  assign dir_up      = (target > pos);
  // stop gates the pulse combinationally so the counter never moves in the abort cycle
  assign step        = active && tick && !at_tgt && !stop;
  assign advance     = active && tick && at_tgt;

  assign cnt_en  = step;
  assign cnt_dir = step ? dir_up : DIR_DOWN;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE) && !stop;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      cfg_q    <= '0;
      loops_q  <= '0;
      div_q    <= '0;
      chk_pend <= 1'b0;
      cfg_err  <= 1'b0;
      trk_err  <= 1'b0;
      pos      <= '0;
    end else begin
      chk_pend <= step;
      if (chk_pend && (cnt_gray != bin2gray(pos))) trk_err <= 1'b1;
      if (step) pos <= dir_up ? pos + 1'b1 : pos - 1'b1;

      if (stop && (state != IDLE)) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            cfg_q   <= '{lo: cfg_lo, hi: cfg_hi, mode: cfg_mode};
            loops_q <= cfg_loops;
            div_q   <= cfg_div;
            cfg_err <= (cfg_lo > cfg_hi);
            trk_err <= 1'b0;
            state   <= (cfg_lo > cfg_hi) ? DONE : SEEK;
          end
          SEEK: if (advance) state <= UP;
          UP:   if (advance) state <= cfg_q.mode ? DOWN : DONE;
          DOWN: if (advance) begin
            if (loops_q == LOOP_W'(1)) begin
              state <= DONE;
            end else begin
              // zero means unlimited round trips, so it is never decremented
              if (loops_q != '0) loops_q <= loops_q - 1'b1;
              state <= UP;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Directed bench: stimulus queues expected pulses/done events, a negedge monitor pops and compares.
module tb_gray_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic       stop = 1'b0;
  logic [7:0] cfg_lo = '0;
  logic [7:0] cfg_hi = '0;
  logic       cfg_mode = 1'b0;
  logic [3:0] cfg_loops = '0;
  logic [7:0] cfg_div = '0;
  logic [7:0] cnt_gray;
  logic       cnt_en, cnt_dir, busy, done, cfg_err, trk_err;
  logic [7:0] pos;

  gray_sweep_ctrl #(.DIV_W(8), .LOOP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .stop(stop), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_mode(cfg_mode),
    .cfg_loops(cfg_loops), .cfg_div(cfg_div), .cnt_gray(cnt_gray), .cnt_en(cnt_en),
    .cnt_dir(cnt_dir), .busy(busy), .done(done), .cfg_err(cfg_err), .trk_err(trk_err),
    .pos(pos)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural gray counter the sequencer drives; corrupt flips a bit of its output.
  logic [7:0] mdl;
  logic       corrupt = 1'b0;
  function automatic logic [7:0] gmap(input logic [7:0] b);
    logic [3:0] h, l;
    h = b[7:4];
    l = b[3:0];
    return {h ^ (h >> 1), l ^ (l >> 1)};
  endfunction
  always @(posedge clk) begin
    if (rst_n)       mdl <= '0;
    else if (cnt_en) mdl <= cnt_dir ? mdl + 8'd1 : mdl - 8'd1;
  end
  assign cnt_gray = gmap(mdl) ^ (corrupt ? 8'h80 : 8'h00);

  typedef struct {
    bit       is_done;
    int       cyc;
    bit       dir;
    bit [7:0] pos;
    bit       ce;
    bit       te;
  } exp_t;
  exp_t q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_pulse(input int c, input bit d);
    q.push_back('{is_done: 1'b0, cyc: c, dir: d, pos: 8'd0, ce: 1'b0, te: 1'b0});
  endtask

  task automatic push_done(input int c, input bit [7:0] p, input bit ce, input bit te);
    q.push_back('{is_done: 1'b1, cyc: c, dir: 1'b0, pos: p, ce: ce, te: te});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cnt_en === 1'b1 || done === 1'b1) begin
      if (q.size() == 0) begin
        check(cnt_en ? "unexpected_pulse" : "unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("event_kind", {31'd0, done}, {31'd0, e.is_done});
        check("event_cyc", cyc, e.cyc);
        if (e.is_done) begin
          check("done_pos", pos, e.pos);
          check("done_cfg_err", cfg_err, e.ce);
          check("done_trk_err", trk_err, e.te);
        end else begin
          check("pulse_dir", cnt_dir, e.dir);
        end
      end
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_cmd(input logic [7:0] lo, input logic [7:0] hi, input logic mode,
                           input logic [3:0] loops, input logic [7:0] div, output int t);
    @(posedge clk);
    #1;
    cfg_lo = lo; cfg_hi = hi; cfg_mode = mode; cfg_loops = loops; cfg_div = div;
    start_valid = 1'b1;
    t = cyc;
  endtask

  task automatic release_start(input int t);
    at_cyc(t + 1);
    start_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  initial begin
    int t;
    // reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_dir", cnt_dir, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_trk_err", trk_err, 0);
    check("rst_pos", pos, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_start_ready", start_ready, 1);

    // single up-sweep from 0: seek to 3, sweep to 5
    start_cmd(8'd3, 8'd5, 1'b0, 4'd0, 8'd0, t);
    push_pulse(t + 1, 1); push_pulse(t + 2, 1); push_pulse(t + 3, 1);
    push_pulse(t + 5, 1); push_pulse(t + 6, 1);
    push_done(t + 8, 8'd5, 1'b0, 1'b0);
    release_start(t);
    at_cyc(t + 7);
    @(negedge clk);
    check("t1_pos_t7", pos, 5);
    wait_idle(20);
    check("t1_idle_cyc", cyc, t + 9);
    check("t1_start_ready", start_ready, 1);
    check("t1_cnt_gray", cnt_gray, 8'h07);

    // same sweep with div = 2 from a fresh reset
    do_reset();
    start_cmd(8'd3, 8'd5, 1'b0, 4'd0, 8'd2, t);
    push_pulse(t + 3, 1); push_pulse(t + 6, 1); push_pulse(t + 9, 1);
    push_pulse(t + 15, 1); push_pulse(t + 18, 1);
    push_done(t + 22, 8'd5, 1'b0, 1'b0);
    release_start(t);
    wait_idle(40);

    // ping-pong 2 round trips from pos 5
    start_cmd(8'd2, 8'd4, 1'b1, 4'd2, 8'd0, t);
    push_pulse(t + 1, 0); push_pulse(t + 2, 0); push_pulse(t + 3, 0);
    push_pulse(t + 5, 1); push_pulse(t + 6, 1);
    push_pulse(t + 8, 0); push_pulse(t + 9, 0);
    push_pulse(t + 11, 1); push_pulse(t + 12, 1);
    push_pulse(t + 14, 0); push_pulse(t + 15, 0);
    push_done(t + 17, 8'd2, 1'b0, 1'b0);
    release_start(t);
    wait_idle(40);
    check("t3_cnt_gray", cnt_gray, 8'h03);

    // lo > hi: immediate done with cfg_err
    start_cmd(8'd9, 8'd4, 1'b0, 4'd0, 8'd0, t);
    push_done(t + 1, 8'd2, 1'b1, 1'b0);
    release_start(t);
    @(negedge clk);
    check("t4_busy", busy, 1);
    check("t4_cfg_err", cfg_err, 1);
    wait_idle(10);

    // stop mid-UP
    start_cmd(8'd2, 8'd10, 1'b0, 4'd0, 8'd0, t);
    push_pulse(t + 2, 1); push_pulse(t + 3, 1);
    release_start(t);
    @(negedge clk);
    check("t5_cfg_err_clr", cfg_err, 0);
    at_cyc(t + 4);
    stop = 1'b1;
    @(negedge clk);
    check("t5_stop_no_pulse", cnt_en, 0);
    at_cyc(t + 5);
    stop = 1'b0;
    @(negedge clk);
    check("t5_stop_idle", busy, 0);
    check("t5_stop_pos", pos, 4);

    // corrupted gray output after one pulse
    start_cmd(8'd4, 8'd6, 1'b0, 4'd0, 8'd0, t);
    push_pulse(t + 2, 1); push_pulse(t + 3, 1);
    push_done(t + 5, 8'd6, 1'b0, 1'b1);
    release_start(t);
    at_cyc(t + 3);
    corrupt = 1'b1;
    at_cyc(t + 4);
    corrupt = 1'b0;
    @(negedge clk);
    check("t5_trk_err_set", trk_err, 1);
    wait_idle(10);
    check("t5_trk_err_held", trk_err, 1);

    // reset mid-SEEK
    start_cmd(8'd1, 8'd3, 1'b0, 4'd0, 8'd0, t);
    push_pulse(t + 1, 0); push_pulse(t + 2, 0);
    release_start(t);
    @(negedge clk);
    check("t6_trk_err_clr", trk_err, 0);
    at_cyc(t + 2);
    rst_n = 1'b1;
    at_cyc(t + 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_cnt_en", cnt_en, 0);
    check("t6_done", done, 0);
    check("t6_pos", pos, 0);
    check("t6_cnt_gray", cnt_gray, 8'h00);

    // start together with stop in IDLE is refused
    @(posedge clk);
    #1;
    cfg_lo = 8'd3; cfg_hi = 8'd5; cfg_mode = 1'b0; cfg_div = 8'd0;
    start_valid = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    check("t6_ready_stop", start_ready, 0);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    check("t6_not_accepted", busy, 0);
    repeat (6) @(negedge clk);
    check("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
